// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan bus: segment patterns (a = MSB),
// idle commons and the BCD value stored for undecodable patterns.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned COM_W      = 8;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned IDX_W      = 3;

  localparam logic [SEG_W-1:0] SEG_0 = 7'h7E;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h33;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h5F;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h72;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h7B;

  localparam logic [COM_W-1:0] COM_IDLE_HI = 8'hFF;
  localparam logic [COM_W-1:0] COM_IDLE_LO = 8'h00;
  localparam logic [BCD_W-1:0] BCD_BAD     = 4'hF;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational segment-pattern to BCD decoder; exact matches only, anything
// else reports invalid with BCD_BAD.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] iSEG,
  output logic             oVALID_c,
  output logic [BCD_W-1:0] oBCD_c
);

  always_comb begin
    oVALID_c = 1'b0;
    oBCD_c   = BCD_BAD;
    case (iSEG)
      SEG_0:   begin oVALID_c = 1'b1; oBCD_c = 4'd0; end
      SEG_1:   begin oVALID_c = 1'b1; oBCD_c = 4'd1; end
      SEG_2:   begin oVALID_c = 1'b1; oBCD_c = 4'd2; end
      SEG_3:   begin oVALID_c = 1'b1; oBCD_c = 4'd3; end
      SEG_4:   begin oVALID_c = 1'b1; oBCD_c = 4'd4; end
      SEG_5:   begin oVALID_c = 1'b1; oBCD_c = 4'd5; end
      SEG_6:   begin oVALID_c = 1'b1; oBCD_c = 4'd6; end
      SEG_7:   begin oVALID_c = 1'b1; oBCD_c = 4'd7; end
      SEG_8:   begin oVALID_c = 1'b1; oBCD_c = 4'd8; end
      SEG_9:   begin oVALID_c = 1'b1; oBCD_c = 4'd9; end
      default: ;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive side of the multiplexed seven-segment scan bus: samples the bus,
// recovers the eight BCD digits and flags complete in-order scan frames.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter bit SEQ_CHECK    = 1'b1,
  parameter bit HOLD_INVALID = 1'b1
) (
  input  logic             iCLK,
  input  logic             nRST,
  input  logic             iCLR,
  input  logic [COM_W-1:0] iS_COM,
  input  logic [SEG_W-1:0] iS_ENS,
  output logic [BCD_W-1:0] oDIG0,
  output logic [BCD_W-1:0] oDIG1,
  output logic [BCD_W-1:0] oDIG2,
  output logic [BCD_W-1:0] oDIG3,
  output logic [BCD_W-1:0] oDIG4,
  output logic [BCD_W-1:0] oDIG5,
  output logic [BCD_W-1:0] oDIG6,
  output logic [BCD_W-1:0] oDIG7,
  output logic [COM_W-1:0] oDVALID,
  output logic             oFRAME,
  output logic             oCOM_ERR,
  output logic             oSEQ_ERR
);

  logic [COM_W-1:0] comQ;
  logic [SEG_W-1:0] ensQ;
  logic             comIdle_c;
  logic             capture_c;
  logic             comBad_c;
  logic [IDX_W-1:0] comIdx_c;
  logic             patValid_c;
  logic [BCD_W-1:0] patBcd_c;
  logic             orderBad_c;
  logic [COM_W-1:0] capMask_c;
  logic [COM_W-1:0] seenNext_c;
  logic [COM_W-1:0] seen;
  logic [IDX_W-1:0] expIdx;
  logic             frame;
  logic             comErr;
  logic             seqErr;
  logic [BCD_W-1:0] digQ [NUM_DIGITS];
  logic [COM_W-1:0] dValid;

  // Stage 1: bus sampling; reset value is an idle bus so nothing is captured
  always_ff @(posedge iCLK or posedge nRST) begin
    if (nRST) begin
      comQ <= COM_IDLE_HI;
      ensQ <= '0;
    end else begin
      comQ <= iS_COM;
      ensQ <= iS_ENS;
    end
  end

  // Commons classification and index of the single low bit
  always_comb begin
    comIdle_c = (comQ == COM_IDLE_HI) || (comQ == COM_IDLE_LO);
    capture_c = $onehot(~comQ);
    comBad_c  = !comIdle_c && !capture_c;
    comIdx_c  = '0;
    for (int unsigned i = 0; i < COM_W; i++) begin
      if (!comQ[i]) comIdx_c = IDX_W'(i);
    end
  end

  seg7_to_bcd uDecode (
    .iSEG     (ensQ),
    .oVALID_c (patValid_c),
    .oBCD_c   (patBcd_c)
  );

  // An out-of-order capture restarts the frame at the captured digit
  always_comb begin
    orderBad_c = SEQ_CHECK && (comIdx_c != expIdx);
    capMask_c  = COM_W'(1) << comIdx_c;
    seenNext_c = orderBad_c ? capMask_c : (seen | capMask_c);
  end

  // Frame tracker and sticky error flags; iCLR overrides any error set
  always_ff @(posedge iCLK or posedge nRST) begin
    if (nRST) begin
      seen   <= '0;
      expIdx <= '0;
      frame  <= 1'b0;
      comErr <= 1'b0;
      seqErr <= 1'b0;
    end else begin
      frame <= 1'b0;
      if (iCLR) begin
        seen   <= '0;
        expIdx <= '0;
        comErr <= 1'b0;
        seqErr <= 1'b0;
      end else if (comBad_c) begin
        seen   <= '0;
        expIdx <= '0;
        comErr <= 1'b1;
      end else if (capture_c) begin
        if (orderBad_c) seqErr <= 1'b1;
        expIdx <= comIdx_c + IDX_W'(1);
        if (comIdx_c == IDX_W'(NUM_DIGITS - 1)) begin
          seen  <= '0;
          frame <= &seenNext_c;
        end else begin
          seen <= seenNext_c;
        end
      end
    end
  end

  // Digit register file; captures decode even in an iCLR cycle
  always_ff @(posedge iCLK or posedge nRST) begin
    if (nRST) begin
      digQ   <= '{default: '0};
      dValid <= '0;
    end else if (capture_c) begin
      dValid[comIdx_c] <= patValid_c;
      if (patValid_c)        digQ[comIdx_c] <= patBcd_c;
      else if (!HOLD_INVALID) digQ[comIdx_c] <= BCD_BAD;
    end
  end

  assign oDIG0    = digQ[0];
  assign oDIG1    = digQ[1];
  assign oDIG2    = digQ[2];
  assign oDIG3    = digQ[3];
  assign oDIG4    = digQ[4];
  assign oDIG5    = digQ[5];
  assign oDIG6    = digQ[6];
  assign oDIG7    = digQ[7];
  assign oDVALID  = dValid;
  assign oFRAME   = frame;
  assign oCOM_ERR = comErr;
  assign oSEQ_ERR = seqErr;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scan sweeps plus randomized bus traffic,
// checked every cycle against a rule-level reference model.
module tb_seg7_scan_decoder;

  logic       iCLK = 1'b0;
  logic       nRST;
  logic       iCLR;
  logic [7:0] iS_COM;
  logic [6:0] iS_ENS;
  logic [3:0] oDIG0, oDIG1, oDIG2, oDIG3, oDIG4, oDIG5, oDIG6, oDIG7;
  logic [7:0] oDVALID;
  logic       oFRAME, oCOM_ERR, oSEQ_ERR;
  logic [3:0] digW [8];

  always #5 iCLK = ~iCLK;

  seg7_scan_decoder dut (
    .iCLK(iCLK), .nRST(nRST), .iCLR(iCLR), .iS_COM(iS_COM), .iS_ENS(iS_ENS),
    .oDIG0(oDIG0), .oDIG1(oDIG1), .oDIG2(oDIG2), .oDIG3(oDIG3),
    .oDIG4(oDIG4), .oDIG5(oDIG5), .oDIG6(oDIG6), .oDIG7(oDIG7),
    .oDVALID(oDVALID), .oFRAME(oFRAME), .oCOM_ERR(oCOM_ERR), .oSEQ_ERR(oSEQ_ERR)
  );

  assign digW[0] = oDIG0;
  assign digW[1] = oDIG1;
  assign digW[2] = oDIG2;
  assign digW[3] = oDIG3;
  assign digW[4] = oDIG4;
  assign digW[5] = oDIG5;
  assign digW[6] = oDIG6;
  assign digW[7] = oDIG7;

  int nErr = 0;
  int nChk = 0;
  int frameCnt = 0;
  logic [6:0] segTab [10];

  // Reference model state: digits, validity, frame set, expected next digit
  int  mDig [8];
  bit  mVal [8];
  bit  mSeen [8];
  int  mExp;
  bit  mFrame, mComErr, mSeqErr;
  logic [7:0] pCom;
  logic [6:0] pEns;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nChk++;
    if (obs !== expv) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic modelReset();
    for (int j = 0; j < 8; j++) begin
      mDig[j] = 0; mVal[j] = 0; mSeen[j] = 0;
    end
    mExp = 0; mFrame = 0; mComErr = 0; mSeqErr = 0;
    pCom = 8'hFF; pEns = 7'h00;
  endtask

  task automatic modelStep(input logic [7:0] com, input logic [6:0] ens, input bit clr);
    int zeros = 0;
    int k = 0;
    int v = -1;
    bit all;
    mFrame = 0;
    for (int i = 0; i < 8; i++) if (com[i] == 1'b0) begin zeros++; k = i; end
    if (com == 8'hFF || com == 8'h00) begin
      // idle bus: nothing happens
    end else if (zeros == 1) begin
      for (int d = 0; d < 10; d++) if (ens == segTab[d]) v = d;
      if (v >= 0) begin mDig[k] = v; mVal[k] = 1; end
      else mVal[k] = 0;
      if (!clr) begin
        if (k != mExp) begin
          mSeqErr = 1;
          for (int j = 0; j < 8; j++) mSeen[j] = 0;
        end
        mSeen[k] = 1;
        mExp = (k + 1) % 8;
        if (k == 7) begin
          all = 1;
          for (int j = 0; j < 8; j++) all &= mSeen[j];
          mFrame = all;
          for (int j = 0; j < 8; j++) mSeen[j] = 0;
        end
      end
    end else if (!clr) begin
      mComErr = 1;
      for (int j = 0; j < 8; j++) mSeen[j] = 0;
      mExp = 0;
    end
    if (clr) begin
      mComErr = 0; mSeqErr = 0; mExp = 0;
      for (int j = 0; j < 8; j++) mSeen[j] = 0;
    end
  endtask

  task automatic compareAll();
    logic [7:0] vMask;
    for (int k = 0; k < 8; k++) begin
      checkVal($sformatf("dig%0d", k), 32'(digW[k]), 32'(mDig[k]));
      vMask[k] = mVal[k];
    end
    checkVal("dvalid", 32'(oDVALID), 32'(vMask));
    checkVal("frame", 32'(oFRAME), 32'(mFrame));
    checkVal("comErr", 32'(oCOM_ERR), 32'(mComErr));
    checkVal("seqErr", 32'(oSEQ_ERR), 32'(mSeqErr));
    if (oFRAME === 1'b1) frameCnt++;
  endtask

  // One bus cycle: drive at the falling edge, advance model, check next falling edge
  task automatic busCycle(input logic [7:0] com, input logic [6:0] ens, input bit clr);
    iS_COM = com; iS_ENS = ens; iCLR = clr;
    @(posedge iCLK);
    modelStep(pCom, pEns, clr);
    pCom = com; pEns = ens;
    @(negedge iCLK);
    compareAll();
  endtask

  task automatic driveDigit(input int k, input logic [6:0] ens);
    logic [7:0] one = 8'h01;
    busCycle(~(one << k), ens, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) busCycle(8'hFF, 7'h00, 1'b0);
  endtask

  task automatic sweep(input int v [8]);
    for (int k = 0; k < 8; k++) driveDigit(k, segTab[v[k]]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int pi [8] = '{3, 1, 4, 1, 5, 9, 2, 6};
    int vv [8];
    int nextIdx = 0;
    int r;
    logic [6:0] ens;

    segTab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h72, 7'h7F, 7'h7B};
    nRST = 1'b1; iCLR = 1'b0; iS_COM = 8'h00; iS_ENS = 7'h00;
    modelReset();
    repeat (3) @(negedge iCLK);
    compareAll();
    nRST = 1'b0;

    // Driver scan begins at digit 1 after its reset
    for (int k = 1; k < 8; k++) driveDigit(k, segTab[k]);
    idle(2);
    checkVal("startSeqErr", 32'(oSEQ_ERR), 32'd1);
    busCycle(8'hFF, 7'h00, 1'b1);
    checkVal("startSeqErrClr", 32'(oSEQ_ERR), 32'd0);

    // "31415926" in order
    frameCnt = 0;
    sweep(pi);
    idle(2);
    for (int k = 0; k < 8; k++) checkVal($sformatf("piDig%0d", k), 32'(digW[k]), 32'(pi[k]));
    checkVal("piValid", 32'(oDVALID), 32'hFF);
    checkVal("piFrames", 32'(frameCnt), 32'd1);

    // Illegal commons: sticky error, cleared by iCLR
    busCycle(8'hF3, segTab[8], 1'b0);
    idle(2);
    checkVal("comErrSet", 32'(oCOM_ERR), 32'd1);
    checkVal("comErrDig", 32'(oDIG3), 32'd1);
    busCycle(8'hFF, 7'h00, 1'b1);
    checkVal("comErrClr", 32'(oCOM_ERR), 32'd0);

    // Undecodable pattern on digit 2 still completes the frame
    frameCnt = 0;
    for (int k = 0; k < 8; k++) driveDigit(k, (k == 2) ? 7'h01 : segTab[pi[k]]);
    idle(2);
    checkVal("badPatValid", 32'(oDVALID), 32'hFB);
    checkVal("badPatHold", 32'(oDIG2), 32'd4);
    checkVal("badPatFrames", 32'(frameCnt), 32'd1);

    // Skipped digit 3: order error, no frame until a clean sweep
    frameCnt = 0;
    for (int k = 0; k < 8; k++) if (k != 3) driveDigit(k, segTab[k]);
    idle(2);
    checkVal("skipSeqErr", 32'(oSEQ_ERR), 32'd1);
    checkVal("skipFrames", 32'(frameCnt), 32'd0);
    sweep(pi);
    idle(2);
    checkVal("recoverFrames", 32'(frameCnt), 32'd1);
    busCycle(8'hFF, 7'h00, 1'b1);

    // Asynchronous reset in the middle of a frame
    for (int k = 0; k < 5; k++) driveDigit(k, segTab[7]);
    #2 nRST = 1'b1;
    iS_COM = 8'h00;
    #1;
    checkVal("rstDig0", 32'(oDIG0), 32'd0);
    checkVal("rstDig3", 32'(oDIG3), 32'd0);
    checkVal("rstValid", 32'(oDVALID), 32'd0);
    checkVal("rstErr", 32'({oFRAME, oCOM_ERR, oSEQ_ERR}), 32'd0);
    modelReset();
    repeat (2) @(negedge iCLK);
    nRST = 1'b0;
    frameCnt = 0;
    sweep(pi);
    idle(2);
    checkVal("postRstFrames", 32'(frameCnt), 32'd1);
    checkVal("postRstComErr", 32'(oCOM_ERR), 32'd0);

    // Back-to-back frames with digit 5 changing
    frameCnt = 0;
    vv = pi;
    vv[5] = 0; sweep(vv); checkVal("b2bDig5a", 32'(oDIG5), 32'd0);
    vv[5] = 9; sweep(vv); checkVal("b2bDig5b", 32'(oDIG5), 32'd9);
    vv[5] = 7; sweep(vv); checkVal("b2bDig5c", 32'(oDIG5), 32'd7);
    idle(2);
    checkVal("b2bFrames", 32'(frameCnt), 32'd3);

    // Randomized traffic: mostly in-order scans with noise, idles, bad commons, clears
    busCycle(8'hFF, 7'h00, 1'b1);
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      ens = ($urandom_range(0, 4) == 0) ? 7'($urandom) : segTab[$urandom_range(0, 9)];
      if (r < 70) begin
        driveDigit(nextIdx, ens);
        nextIdx = (nextIdx + 1) % 8;
      end else if (r < 80) begin
        driveDigit(int'($urandom_range(0, 7)), ens);
      end else if (r < 86) begin
        busCycle(($urandom_range(0, 1) == 0) ? 8'hFF : 8'h00, ens, 1'b0);
      end else if (r < 93) begin
        busCycle(8'($urandom), ens, 1'b0);
      end else begin
        busCycle(8'($urandom), ens, 1'b1);
      end
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
